joypad_i2c_target: RTL
======================

Name: joypad_i2c_target

Overview:
- I2C target (responder) that emulates the joypad peripheral polled by the invaders core's I2C controller.
- Used in simulation benches, and on a second board, to serve live button state over the same two-wire bus.
- Samples SCL/SDA, decodes START/STOP, matches a 7-bit address, accepts a register-pointer write, and returns auto-incrementing register bytes on reads.
- Drives SDA open-drain style: 0 pulls the line low, 1 releases it.

Parameters:
- TARGET_ADDR, 7'h52, 7-bit bus address the block answers to.
- DEVICE_ID, 8'hA5, constant byte returned from register 2.
- SDA_HOLD, 4, clk cycles after a detected SCL fall before sda_out may change (data hold time).

Ports:
- clk  input  1  system clock; all logic runs on its rising edge.
- rst_n  input  1  synchronous reset, active-low.
- scl_in  input  1  raw SCL level from the bus (asynchronous).
- sda_in  input  1  raw SDA level from the bus (asynchronous).
- sda_out  output  1  0 = pull SDA low, 1 = release.
- buttons  input  16  live button levels, 1 = pressed.
- busy  output  1  high from an address match until the next STOP/START.
- rd_strobe  output  1  one-cycle pulse when a data byte has been fully shifted out and the controller has acked or nacked it.

Behaviour:
- **Input sync.** scl_in/sda_in pass through 2-flop synchronizers, then a 3-sample majority filter. Edges are detected on the filtered signals.
  - scl_rise / scl_fall: single-cycle pulses.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- **Register map.**
  - 0 = buttons[7:0]; 1 = buttons[15:8]; 2 = DEVICE_ID.
  - Pointer 3..255 reads 8'hFF.
- **Snapshot.** buttons is latched into a 16-bit snapshot at every START/repeated START. Reads within one transaction are coherent.
- **Pointer.** 8-bit register pointer.
  - After each read byte: increments, wrapping 2 -> 0; values >= 3 stay put.
  - A write transaction's first data byte loads the pointer; later write bytes are acked and discarded.
- **FSM states:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
  - IDLE: wait for START -> ADDR. Bit counter cleared.
  - ADDR: shift 8 bits MSB-first on scl_rise. On the 8th rise, compare [7:1] with TARGET_ADDR.
    - Match -> ADDR_ACK, busy=1, direction latched from bit 0.
    - Mismatch -> IDLE; sda_out stays 1.
  - ADDR_ACK: at the SDA_HOLD point after the 8th scl_fall, sda_out=0. Release at the SDA_HOLD point after the 9th scl_fall.
    - R/W=0 -> WR_BYTE.
    - R/W=1 -> RD_BYTE, preloading the shift register from the current pointer.
  - WR_BYTE: shift 8 bits -> WR_ACK; drive ack as in ADDR_ACK -> WR_BYTE.
  - RD_BYTE: at the SDA_HOLD point after each scl_fall, present the next bit MSB-first. The first bit is driven at the SDA_HOLD point after the ACK's 9th fall. After the 8th bit's scl_fall, release SDA -> RD_ACK.
  - RD_ACK: sample SDA on scl_rise and pulse rd_strobe.
    - ACK (0): increment pointer, reload shift register -> RD_BYTE.
    - NACK (1): -> IDLE with SDA released.
- **Bus conditions in any state.**
  - START: abort, go to ADDR; busy follows address match. Pointer is kept.
  - STOP: go to IDLE, busy=0, sda_out=1.
- **Reset values:** sda_out=1, busy=0, rd_strobe=0, pointer=0, snapshot=0, state IDLE. Reset mid-transfer releases SDA the next cycle.
- **Timing.** SCL is never stretched. The design requires clk >= 16x SCL frequency; SDA_HOLD must stay below the SCL low time.
- **Changes in one cycle.** sda_out changes only while filtered SCL is low. A START/STOP detected in the same cycle as a pending SDA update takes priority.

Decomposition:
- Shared package joypad_i2c_pkg holds:
  - FSM state enum;
  - register index constants (REG_BTN_LO=0, REG_BTN_HI=1, REG_ID=2, NUM_REGS=3);
  - ACK/NACK level constants.
- Sub-module i2c_line_filter: synchronizer plus majority filter plus edge/START/STOP pulses. It is instantiated once for the SCL/SDA pair.
- The top FSM and shift logic live in joypad_i2c_target.

Test Plan:
1. **Reset.** rst_n=0 for 4 cycles with bus idle high -> sda_out=1, busy=0, rd_strobe=0; pointer reads back 0 in the next read.
2. **Sequential read.** buttons=16'h3C81; write 0xA4, ptr=0x00, repeated START, read 0xA5, read 3 bytes ACK,ACK,NACK -> returned bytes 0x81, 0x3C, 0xA5; three rd_strobe pulses; SDA released after NACK.
3. **Address mismatch.** Address byte 0xA6 -> no ACK (SDA stays 1 through 9th clock), busy=0, block ignores remaining bytes until STOP.
4. **Snapshot coherence.** Set ptr=0; buttons changes 16'h0001->16'hFF00 mid-read of byte 0 -> bytes read 0x01, 0x00; next transaction returns 0x00, 0xFF.
5. **Out-of-range pointer and wrap.**
   - ptr=0x07 then read 2 bytes -> 0xFF, 0xFF.
   - ptr=0x02, read 2 bytes -> 0xA5, then 0x81 (wrap to reg 0) with buttons=16'h0081.
6. **Abort mid-transfer.** STOP injected after 4 bits of a read byte -> SDA released within 3 filter cycles, state IDLE, busy=0. A following valid transaction succeeds with the pointer unchanged.

Source files
------------

// File: rtl/joypad_i2c_pkg.sv
// rtl/joypad_i2c_pkg.sv - shared types, constants and helpers for the joypad I2C target
package joypad_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } i2c_state_t;

  localparam logic [7:0] REG_BTN_LO = 8'd0;
  localparam logic [7:0] REG_BTN_HI = 8'd1;
  localparam logic [7:0] REG_ID     = 8'd2;
  localparam logic [7:0] NUM_REGS   = 8'd3;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  // Two-out-of-three vote used to reject single-sample glitches.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Pointer step after an acked read: walk the real registers and wrap,
  // leave out-of-range pointers parked where they are.
  function automatic logic [7:0] ptr_advance(input logic [7:0] ptr);
    if (ptr == NUM_REGS - 8'd1) return REG_BTN_LO;
    else if (ptr < NUM_REGS)    return ptr + 8'd1;
    else                        return ptr;
  endfunction

  // Register file view: button snapshot, fixed ID, everything else reads as all ones.
  function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                          input logic [15:0] snap,
                                          input logic [7:0]  dev_id);
    case (ptr)
      REG_BTN_LO: return snap[7:0];
      REG_BTN_HI: return snap[15:8];
      REG_ID:     return dev_id;
      default:    return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - SCL/SDA synchronizer, majority filter and bus-condition detector
module i2c_line_filter
  import joypad_i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic [2:0] scl_hist;
  logic [2:0] sda_hist;
  logic       scl_q;
  logic       sda_q;

  // Synchronize, keep three samples, vote, and remember the previous filtered level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
      scl      <= 1'b1;
      sda      <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl      <= majority3(scl_hist);
      sda      <= majority3(sda_hist);
      scl_q    <= scl;
      sda_q    <= sda;
    end
  end

  // START/STOP need SCL high on both samples so an SCL edge is never mistaken for one.
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/joypad_i2c_target.sv
// rtl/joypad_i2c_target.sv - I2C target serving a button snapshot and device ID
module joypad_i2c_target
  import joypad_i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h52,
  parameter logic [7:0]  DEVICE_ID   = 8'hA5,
  parameter int unsigned SDA_HOLD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  input  logic [15:0] buttons,
  output logic        busy,
  output logic        rd_strobe
);

  localparam logic [3:0] HOLD_LOAD = 4'(SDA_HOLD);

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl       (scl_f),
    .sda       (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t  state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [6:0]  rx_bits, rx_bits_n;
  logic [7:0]  tx_byte, tx_byte_n;
  logic [7:0]  ptr, ptr_n;
  logic [15:0] snap, snap_n;
  logic        busy_n, rd_strobe_n, sda_out_n;
  logic        rw, rw_n;
  logic        wr_first, wr_first_n;
  logic        sda_pend, sda_pend_n;
  logic [3:0]  hold_cnt, hold_cnt_n;
  logic [7:0]  rx_byte;

  // State and datapath registers; reset releases SDA on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      rx_bits   <= 7'd0;
      tx_byte   <= 8'hFF;
      ptr       <= 8'd0;
      snap      <= 16'd0;
      busy      <= 1'b0;
      rd_strobe <= 1'b0;
      sda_out   <= 1'b1;
      rw        <= 1'b0;
      wr_first  <= 1'b0;
      sda_pend  <= 1'b1;
      hold_cnt  <= 4'd0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx_bits   <= rx_bits_n;
      tx_byte   <= tx_byte_n;
      ptr       <= ptr_n;
      snap      <= snap_n;
      busy      <= busy_n;
      rd_strobe <= rd_strobe_n;
      sda_out   <= sda_out_n;
      rw        <= rw_n;
      wr_first  <= wr_first_n;
      sda_pend  <= sda_pend_n;
      hold_cnt  <= hold_cnt_n;
    end
  end

  // Protocol sequencing: SCL edges advance the byte/ack phases; SDA changes are
  // queued on each SCL fall and applied once the hold counter expires.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    rx_bits_n   = rx_bits;
    tx_byte_n   = tx_byte;
    ptr_n       = ptr;
    snap_n      = snap;
    busy_n      = busy;
    rd_strobe_n = 1'b0;
    sda_out_n   = sda_out;
    rw_n        = rw;
    wr_first_n  = wr_first;
    sda_pend_n  = sda_pend;
    hold_cnt_n  = hold_cnt;
    rx_byte     = {rx_bits, sda_f};

    if (hold_cnt != 4'd0) begin
      hold_cnt_n = hold_cnt - 4'd1;
      if (hold_cnt == 4'd1 && !scl_f) sda_out_n = sda_pend;
    end

    case (state)
      ST_IDLE: begin
        bit_cnt_n = 4'd0;
      end

      ST_ADDR: begin
        if (scl_rise) begin
          rx_bits_n = rx_byte[6:0];
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            if (rx_bits == TARGET_ADDR) begin
              state_n    = ST_ADDR_ACK;
              busy_n     = 1'b1;
              rw_n       = sda_f;
              wr_first_n = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end

      // The 8th fall pulls SDA for the ack; the 9th rise ends the ack phase and
      // the following 9th fall is handled by the byte state we move into.
      ST_ADDR_ACK, ST_WR_ACK: begin
        if (scl_fall) begin
          sda_pend_n = SDA_ACK;
          hold_cnt_n = HOLD_LOAD;
        end
        if (scl_rise) begin
          bit_cnt_n = 4'd0;
          if (state == ST_ADDR_ACK && rw) begin
            state_n   = ST_RD_BYTE;
            tx_byte_n = reg_read(ptr, snap, DEVICE_ID);
          end else begin
            state_n = ST_WR_BYTE;
          end
        end
      end

      ST_WR_BYTE: begin
        if (scl_fall) begin
          sda_pend_n = SDA_NACK;
          hold_cnt_n = HOLD_LOAD;
        end
        if (scl_rise) begin
          rx_bits_n = rx_byte[6:0];
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            state_n   = ST_WR_ACK;
            if (wr_first) ptr_n = rx_byte;
            wr_first_n = 1'b0;
          end
        end
      end

      // Each fall presents the next bit; the fall after bit 0 releases SDA.
      ST_RD_BYTE: begin
        if (scl_fall) begin
          hold_cnt_n = HOLD_LOAD;
          if (bit_cnt < 4'd8) begin
            sda_pend_n = tx_byte[7];
            tx_byte_n  = {tx_byte[6:0], 1'b1};
            bit_cnt_n  = bit_cnt + 4'd1;
          end else begin
            sda_pend_n = SDA_NACK;
            bit_cnt_n  = 4'd0;
            state_n    = ST_RD_ACK;
          end
        end
      end

      ST_RD_ACK: begin
        if (scl_rise) begin
          rd_strobe_n = 1'b1;
          if (sda_f == SDA_ACK) begin
            ptr_n     = ptr_advance(ptr);
            tx_byte_n = reg_read(ptr_advance(ptr), snap, DEVICE_ID);
            bit_cnt_n = 4'd0;
            state_n   = ST_RD_BYTE;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Bus conditions override everything, including a queued SDA update.
    if (start_det) begin
      state_n    = ST_ADDR;
      bit_cnt_n  = 4'd0;
      busy_n     = 1'b0;
      snap_n     = buttons;
      wr_first_n = 1'b0;
      hold_cnt_n = 4'd0;
      sda_pend_n = 1'b1;
      sda_out_n  = 1'b1;
    end else if (stop_det) begin
      state_n    = ST_IDLE;
      bit_cnt_n  = 4'd0;
      busy_n     = 1'b0;
      wr_first_n = 1'b0;
      hold_cnt_n = 4'd0;
      sda_pend_n = 1'b1;
      sda_out_n  = 1'b1;
    end
  end

endmodule
